skew_cal_seq: RTL and testbench
===============================

SKEW_CAL_SEQ -- requirements
Module: skew_cal_seq

Interface
REQ-001 Parameter CH_N, default 4, number of comparator channels to calibrate (2..16).
REQ-002 Parameter MAX_RETRY, default 2, number of retries per channel after a measurement error.
REQ-003 Parameter SETTLE_CYC, default 16, number of clk_i cycles to wait after releasing the measure-unit reset.
REQ-004 Parameter TIMEOUT_CYC, default 65535, watchdog limit in RUN, in clk_i cycles.
REQ-005 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-006 arstn_i  in  1  asynchronous, active-low reset.
REQ-007 start_i  in  1  single-cycle pulse that starts a calibration sweep.
REQ-008 ch_mask_i  in  CH_N  channels to calibrate; sampled on the accepted start_i.
REQ-009 busy_o  out  1  high from an accepted start until done_o.
REQ-010 done_o  out  1  single-cycle pulse marking the end of the sweep.
REQ-011 err_o  out  1  sticky; set if any channel fails; cleared by the next accepted start.
REQ-012 ch_sel_o  out  $clog2(CH_N)  channel mux select to the measure unit.
REQ-013 mes_arstn_o  out  1  active-low reset to the skew measure unit.
REQ-014 mes_run_o  out  1  run request to the skew measure unit.
REQ-015 mes_rdy_i, mes_err_i  in  1  each  measure-unit result flags (levels).
REQ-016 delay_code_i  in  10  measured delay code.
REQ-017 stb_rdy_i  in  1  strobe generator locked/ready.
REQ-018 res_addr_i  in  $clog2(CH_N)  result read address.
REQ-019 res_code_o  out  10  stored code for the channel at res_addr_i; combinational read.
REQ-020 res_vld_o  out  CH_N  per-channel result-valid bits.
REQ-021 err_mask_o  out  CH_N  per-channel failure bits.

Function
REQ-022 The FSM SHALL have the states IDLE, MRST, SETTLE, RUN, STORE, NEXT and DONE.
REQ-023 In IDLE, start_i SHALL latch the mask, clear res_vld_o, err_mask_o and err_o, assert busy_o, and select the lowest set mask bit.
- If the mask is zero, the FSM goes to DONE directly.
- Otherwise it goes to MRST.
REQ-024 start_i SHALL be ignored while busy_o=1.
REQ-025 In MRST, mes_arstn_o SHALL be held low for exactly 2 cycles; the FSM then goes to SETTLE.
REQ-026 SETTLE SHALL last at least SETTLE_CYC cycles and SHALL exit to RUN only when stb_rdy_i=1.
REQ-027 In RUN, mes_run_o SHALL be 1 and SHALL stay 1 until mes_rdy_i or mes_err_i is seen.
- mes_err_i has priority when both are seen in the same cycle.
REQ-028 On mes_rdy_i, the FSM SHALL go to STORE: write delay_code_i to the selected channel, set its res_vld_o bit, clear the retry count, then go to NEXT.
REQ-029 On mes_err_i:
- If the retry count is below MAX_RETRY, increment it and return to MRST on the same channel.
- Otherwise set the channel's err_mask_o bit, set err_o, store code 0 with res_vld_o=0, and go to NEXT.
REQ-030 NEXT SHALL select the next higher set mask bit and go to MRST; if there is none, it SHALL go to DONE.
REQ-031 DONE SHALL pulse done_o for one cycle, drop busy_o in the same cycle, and return to IDLE.
REQ-032 ch_sel_o SHALL change only in IDLE and NEXT, never while mes_run_o=1.
REQ-033 Stored results SHALL persist until the next accepted start or reset.

Reset
REQ-034 On arstn_i=0 the block SHALL immediately enter IDLE and drive:
- busy_o=0, done_o=0, err_o=0, mes_run_o=0, mes_arstn_o=0, ch_sel_o=0;
- res_vld_o=0, err_mask_o=0, all stored codes=0.
REQ-035 mes_arstn_o SHALL be 1 in IDLE after reset release, and low only in MRST and during reset.
REQ-036 Reset mid-sweep SHALL abort the sweep without a done_o pulse.

Configuration
REQ-037 With SKEW_CAL_TIMEOUT_EN defined, a cycle counter SHALL run in RUN; reaching TIMEOUT_CYC SHALL be handled exactly as mes_err_i.
REQ-038 Without SKEW_CAL_TIMEOUT_EN, there is no counter, and RUN waits indefinitely for mes_rdy_i or mes_err_i.

Structure
REQ-039 Package skew_cal_pkg SHALL hold:
- the FSM state enum;
- DELAY_CODE_W=10;
- a result struct {code, vld, err}.
REQ-040 The result storage SHALL be a sub-module skew_cal_regs: CH_N x 10-bit registers with valid/err bits, a write port and an asynchronous read port.

Verification
REQ-041 Mask 4'b0101, model returns rdy with codes 123 and 456 -> runs on ch 0 then ch 2; res_code 123/456; res_vld 0101; one done_o pulse; err_o=0.
REQ-042 Mask 4'b0010, model errs twice then succeeds with code 77 (MAX_RETRY=2) -> three MRST entries; res_vld 0010; err_o=0.
REQ-043 Mask 4'b0001, model always errs -> three runs; err_mask 0001; err_o=1; done_o pulses.
REQ-044 Mask 0 -> done_o 2 cycles after start, mes_run_o never asserted; a start_i mid-sweep is ignored.
REQ-045 With SKEW_CAL_TIMEOUT_EN and TIMEOUT_CYC=100, model silent -> run drops after 100 cycles and retries; with stb_rdy_i=0, the FSM stays in SETTLE.
REQ-046 Reset asserted in RUN -> all outputs at reset values the same cycle; no done_o pulse.

Source files
------------

// File: rtl/skew_cal_pkg.sv
// Shared types for the skew calibration sequencer: FSM states, result record
// and the mask-scan helper used to walk the channel mask.
package skew_cal_pkg;

  localparam int DELAY_CODE_W = 10;
  localparam logic [4:0] NO_CH = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MRST,
    S_SETTLE,
    S_RUN,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [DELAY_CODE_W-1:0] code;
    logic                    vld;
    logic                    err;
  } res_t;

  // Lowest set bit at index >= from; NO_CH when none is left.
  function automatic logic [4:0] first_set_from(input logic [15:0] mask, input int from);
    logic [4:0] r;
    r = NO_CH;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/skew_cal_regs.sv
// Per-channel calibration result store: one write port, asynchronous read of
// the code, flat valid/error vectors. Write is taken on the next clk_i edge.
module skew_cal_regs
  import skew_cal_pkg::*;
#(
  parameter int CH_N = 4,
  parameter int AW   = $clog2(CH_N)
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    clr_i,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [DELAY_CODE_W-1:0] wr_code_i,
  input  logic                    wr_vld_i,
  input  logic                    wr_err_i,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [DELAY_CODE_W-1:0] rd_code_o,
  output logic [CH_N-1:0]         vld_o,
  output logic [CH_N-1:0]         err_o
);

  res_t r_mem [CH_N];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < CH_N; i++) r_mem[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < CH_N; i++) r_mem[i] <= '0;
    end else if (wr_en_i && (int'(wr_addr_i) < CH_N)) begin
      r_mem[wr_addr_i] <= '{code: wr_code_i, vld: wr_vld_i, err: wr_err_i};
    end
  end

  // Non-power-of-two CH_N leaves unused addresses; those read as zero.
  always_comb begin
    rd_code_o = '0;
    if (int'(rd_addr_i) < CH_N) rd_code_o = r_mem[rd_addr_i].code;
    for (int i = 0; i < CH_N; i++) begin
      vld_o[i] = r_mem[i].vld;
      err_o[i] = r_mem[i].err;
    end
  end

endmodule

// File: rtl/skew_cal_seq.sv
// Sweeps masked channels: reset measure unit, settle, run, store code, retry on error.
// Control outputs are registered; define SKEW_CAL_TIMEOUT_EN for a RUN watchdog.
module skew_cal_seq
  import skew_cal_pkg::*;
#(
  parameter int CH_N        = 4,
  parameter int MAX_RETRY   = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    start_i,
  input  logic [CH_N-1:0]         ch_mask_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [$clog2(CH_N)-1:0] ch_sel_o,
  output logic                    mes_arstn_o,
  output logic                    mes_run_o,
  input  logic                    mes_rdy_i,
  input  logic                    mes_err_i,
  input  logic [9:0]              delay_code_i,
  input  logic                    stb_rdy_i,
  input  logic [$clog2(CH_N)-1:0] res_addr_i,
  output logic [9:0]              res_code_o,
  output logic [CH_N-1:0]         res_vld_o,
  output logic [CH_N-1:0]         err_mask_o
);

  localparam int SEL_W = $clog2(CH_N);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1) + 1;
  localparam int RT_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t                  r_state, w_state_n;
  logic                    r_busy, w_busy_n;
  logic                    r_done, w_done_n;
  logic                    r_err, w_err_n;
  logic                    r_run, r_mes_arstn;
  logic [SEL_W-1:0]        r_ch_sel, w_ch_sel_n;
  logic [CH_N-1:0]         r_mask, w_mask_n;
  logic [RT_W-1:0]         r_retry, w_retry_n;
  logic [CNT_W-1:0]        r_cnt, w_cnt_n;
  logic [DELAY_CODE_W-1:0] r_code, w_code_n;
  logic                    w_clr, w_wr_en, w_wr_vld, w_wr_err;
  logic [DELAY_CODE_W-1:0] w_wr_code;
  logic [4:0]              w_first_start, w_first_next;
  logic                    w_timeout, w_fail;

  assign w_first_start = first_set_from(16'(ch_mask_i), 0);
  assign w_first_next  = first_set_from(16'(r_mask), int'(r_ch_sel) + 1);

`ifdef SKEW_CAL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)               r_to_cnt <= '0;
    else if (r_state != S_RUN)  r_to_cnt <= '0;
    else                        r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_RUN) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // A watchdog expiry is indistinguishable from a measure-unit error.
  assign w_fail = mes_err_i | w_timeout;

  always_comb begin
    w_state_n  = r_state;
    w_busy_n   = r_busy;
    w_done_n   = 1'b0;
    w_err_n    = r_err;
    w_ch_sel_n = r_ch_sel;
    w_mask_n   = r_mask;
    w_retry_n  = r_retry;
    w_cnt_n    = r_cnt;
    w_code_n   = r_code;
    w_clr      = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_code  = '0;
    w_wr_vld   = 1'b0;
    w_wr_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_mask_n  = ch_mask_i;
          w_clr     = 1'b1;
          w_err_n   = 1'b0;
          w_busy_n  = 1'b1;
          w_retry_n = '0;
          w_cnt_n   = '0;
          if (w_first_start == NO_CH) begin
            w_state_n = S_DONE;
          end else begin
            w_ch_sel_n = w_first_start[SEL_W-1:0];
            w_state_n  = S_MRST;
          end
        end
      end
      S_MRST: begin
        if (r_cnt == CNT_W'(1)) begin
          w_cnt_n   = '0;
          w_state_n = S_SETTLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt >= CNT_W'(SETTLE_CYC - 1)) begin
          if (stb_rdy_i) begin
            w_cnt_n   = '0;
            w_state_n = S_RUN;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_fail) begin
          if (r_retry < RT_W'(MAX_RETRY)) begin
            w_retry_n = r_retry + 1'b1;
            w_cnt_n   = '0;
            w_state_n = S_MRST;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_err  = 1'b1;
            w_err_n   = 1'b1;
            w_retry_n = '0;
            w_state_n = S_NEXT;
          end
        end else if (mes_rdy_i) begin
          w_code_n  = delay_code_i;
          w_state_n = S_STORE;
        end
      end
      S_STORE: begin
        w_wr_en   = 1'b1;
        w_wr_code = r_code;
        w_wr_vld  = 1'b1;
        w_retry_n = '0;
        w_state_n = S_NEXT;
      end
      S_NEXT: begin
        if (w_first_next == NO_CH) begin
          w_state_n = S_DONE;
        end else begin
          w_ch_sel_n = w_first_next[SEL_W-1:0];
          w_cnt_n    = '0;
          w_state_n  = S_MRST;
        end
      end
      S_DONE: begin
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Run and measure-reset are decoded from the next state so they line up
  // with the state register while still resetting to zero.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_run       <= 1'b0;
      r_mes_arstn <= 1'b0;
      r_ch_sel    <= '0;
      r_mask      <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_code      <= '0;
    end else begin
      r_state     <= w_state_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_err       <= w_err_n;
      r_run       <= (w_state_n == S_RUN);
      r_mes_arstn <= (w_state_n != S_MRST);
      r_ch_sel    <= w_ch_sel_n;
      r_mask      <= w_mask_n;
      r_retry     <= w_retry_n;
      r_cnt       <= w_cnt_n;
      r_code      <= w_code_n;
    end
  end

  skew_cal_regs #(.CH_N(CH_N), .AW(SEL_W)) u_regs (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .clr_i     (w_clr),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (r_ch_sel),
    .wr_code_i (w_wr_code),
    .wr_vld_i  (w_wr_vld),
    .wr_err_i  (w_wr_err),
    .rd_addr_i (res_addr_i),
    .rd_code_o (res_code_o),
    .vld_o     (res_vld_o),
    .err_o     (err_mask_o)
  );

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign ch_sel_o    = r_ch_sel;
  assign mes_arstn_o = r_mes_arstn;
  assign mes_run_o   = r_run;

endmodule

// File: tb/tb_skew_cal_seq.sv
// Scoreboard bench for skew_cal_seq: a per-sweep model predicts run order,
// measure-reset count and final results; a monitor checks them as they appear.
module tb_skew_cal_seq;

  localparam int CH_N       = 4;
  localparam int MAX_RETRY  = 2;
  localparam int SETTLE_CYC = 16;

  typedef struct {
    logic [CH_N-1:0]    mask;
    logic [CH_N-1:0]    vld;
    logic [CH_N-1:0]    errm;
    int                 err;
    int                 mrst;
    logic [CH_N*10-1:0] codes;
  } sum_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            arstn_i, start_i, mes_rdy_i, mes_err_i, stb_rdy_i;
  logic [CH_N-1:0] ch_mask_i;
  logic [9:0]      delay_code_i;
  logic [1:0]      res_addr_i;
  logic            busy_o, done_o, err_o, mes_arstn_o, mes_run_o;
  logic [1:0]      ch_sel_o;
  logic [9:0]      res_code_o;
  logic [CH_N-1:0] res_vld_o, err_mask_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   q_run[$];
  sum_t q_sum[$];
  int   out_q[CH_N][$];
  bit   stb_hold = 1'b0;

  skew_cal_seq #(.CH_N(CH_N), .MAX_RETRY(MAX_RETRY), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(65535)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .start_i(start_i), .ch_mask_i(ch_mask_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ch_sel_o(ch_sel_o),
    .mes_arstn_o(mes_arstn_o), .mes_run_o(mes_run_o), .mes_rdy_i(mes_rdy_i),
    .mes_err_i(mes_err_i), .delay_code_i(delay_code_i), .stb_rdy_i(stb_rdy_i),
    .res_addr_i(res_addr_i), .res_code_o(res_code_o), .res_vld_o(res_vld_o),
    .err_mask_o(err_mask_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe generator: mostly ready, unless a test holds it off.
  initial begin
    stb_rdy_i = 1'b1;
    forever begin
      @(negedge clk_i);
      stb_rdy_i = stb_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Measure unit: per-channel outcome queue, -1 = error, else the code to report.
  initial begin
    int age, lat, outc;
    mes_rdy_i = 1'b0; mes_err_i = 1'b0; delay_code_i = '0;
    age = 0; lat = 1; outc = -1;
    forever begin
      @(negedge clk_i);
      if (!arstn_i || !mes_run_o) begin
        mes_rdy_i = 1'b0; mes_err_i = 1'b0; age = 0;
        delay_code_i = 10'($urandom);
      end else begin
        if (age == 0) begin
          lat  = $urandom_range(1, 5);
          outc = (out_q[ch_sel_o].size() > 0) ? out_q[ch_sel_o].pop_front() : -1;
        end
        age++;
        if (age == lat) begin
          if (outc < 0) mes_err_i = 1'b1;
          else begin
            mes_rdy_i = 1'b1;
            delay_code_i = outc[9:0];
          end
        end
      end
    end
  end

  // Monitor: run order, measure-reset width, settle time, end-of-sweep results.
  initial begin
    bit prev_run, prev_mar;
    int lo_cnt, settle_cnt, mrst_n, run_ch;
    sum_t s;
    prev_run = 0; prev_mar = 1; lo_cnt = 0; settle_cnt = 0; mrst_n = 0; run_ch = 0;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        prev_run = 0; prev_mar = 1; lo_cnt = 0; settle_cnt = 0; mrst_n = 0;
        continue;
      end
      if (!mes_arstn_o) begin
        if (prev_mar) mrst_n++;
        lo_cnt++;
        settle_cnt = 0;
      end else begin
        if (lo_cnt != 0) chk("mrst_len", lo_cnt, 2);
        lo_cnt = 0;
        if (!mes_run_o) settle_cnt++;
      end
      if (mes_run_o && !prev_run) begin
        chk("run_expected", int'(q_run.size() > 0), 1);
        if (q_run.size() > 0) chk("run_ch", int'(ch_sel_o), q_run.pop_front());
        chk("settle_min", int'(settle_cnt >= SETTLE_CYC), 1);
        run_ch = int'(ch_sel_o);
      end
      if (!mes_run_o && prev_run) chk("ch_stable_in_run", int'(ch_sel_o), run_ch);
      if (done_o) begin
        chk("done_expected", int'(q_sum.size() > 0), 1);
        if (q_sum.size() > 0) begin
          s = q_sum.pop_front();
          chk("res_vld", int'(res_vld_o), int'(s.vld));
          chk("err_mask", int'(err_mask_o), int'(s.errm));
          chk("err_o", int'(err_o), s.err);
          chk("busy_with_done", int'(busy_o), 0);
          chk("mrst_entries", mrst_n, s.mrst);
          for (int c = 0; c < CH_N; c++) begin
            if (s.mask[c]) begin
              res_addr_i = 2'(c);
              #1;
              chk("res_code", int'(res_code_o), int'(s.codes[c*10 +: 10]));
            end
          end
        end
        mrst_n = 0;
      end
      prev_run = mes_run_o;
      prev_mar = mes_arstn_o;
    end
  end

  task automatic pulse_start(input logic [CH_N-1:0] m);
    @(posedge clk_i); #1;
    start_i = 1'b1; ch_mask_i = m;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Reference: each masked channel, lowest first, gets min(f+1, MAX_RETRY+1)
  // attempts and succeeds only when f <= MAX_RETRY errors precede the success.
  task automatic sweep(input logic [CH_N-1:0] mask, input int f[CH_N], input int cd[CH_N], input bit hold);
    sum_t s;
    int att;
    bit ok, saw;
    s.mask = mask; s.vld = '0; s.errm = '0; s.mrst = 0; s.codes = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (mask[c]) begin
        att = (f[c] + 1 < MAX_RETRY + 1) ? f[c] + 1 : MAX_RETRY + 1;
        for (int a = 0; a < att; a++) begin
          q_run.push_back(c);
          out_q[c].push_back((a < f[c]) ? -1 : cd[c]);
        end
        s.mrst += att;
        if (f[c] <= MAX_RETRY) begin
          s.vld[c] = 1'b1;
          s.codes[c*10 +: 10] = 10'(cd[c]);
        end else begin
          s.errm[c] = 1'b1;
        end
      end
    end
    s.err = (s.errm != 0) ? 1 : 0;
    q_sum.push_back(s);
    pulse_start(mask);
    if (hold) begin
      stb_hold = 1'b1;
      saw = 0;
      repeat (60) begin
        @(posedge clk_i); #1;
        if (mes_run_o) saw = 1;
      end
      chk("settle_hold_no_run", int'(saw), 0);
      stb_hold = 1'b0;
    end
    repeat (20) @(posedge clk_i);
    #1;
    if (busy_o) begin
      start_i = 1'b1; ch_mask_i = ~mask;
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o) begin ok = 1; break; end
    end
    chk("sweep_finishes", int'(ok), 1);
    repeat (3) @(posedge clk_i);
  endtask

  initial begin
    int f[CH_N];
    int cd[CH_N];
    bit ok, saw;
    sum_t z;
    arstn_i = 1'b0; start_i = 1'b0; ch_mask_i = '0; res_addr_i = '0;
    #2;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_run", int'(mes_run_o), 0);
    chk("rst_mes_arstn", int'(mes_arstn_o), 0);
    chk("rst_ch_sel", int'(ch_sel_o), 0);
    chk("rst_vld", int'(res_vld_o), 0);
    chk("rst_errm", int'(err_mask_o), 0);
    chk("rst_code", int'(res_code_o), 0);
    #10 arstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 chk("idle_mes_arstn", int'(mes_arstn_o), 1);

    f = '{0, 0, 0, 0}; cd = '{123, 0, 456, 0};
    sweep(4'b0101, f, cd, 1'b0);
    f = '{0, 2, 0, 0}; cd = '{0, 77, 0, 0};
    sweep(4'b0010, f, cd, 1'b0);
    f = '{3, 0, 0, 0}; cd = '{5, 0, 0, 0};
    sweep(4'b0001, f, cd, 1'b0);
    f = '{0, 0, 0, 1}; cd = '{0, 0, 0, 999};
    sweep(4'b1000, f, cd, 1'b1);

    z.mask = '0; z.vld = '0; z.errm = '0; z.err = 0; z.mrst = 0; z.codes = '0;
    q_sum.push_back(z);
    pulse_start(4'b0000);
    chk("mask0_busy", int'(busy_o), 1);
    chk("mask0_done_early", int'(done_o), 0);
    @(posedge clk_i); #1;
    chk("mask0_done", int'(done_o), 1);
    chk("mask0_busy_drop", int'(busy_o), 0);
    repeat (3) @(posedge clk_i);

    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < CH_N; c++) begin
        f[c]  = $urandom_range(0, 3);
        cd[c] = $urandom_range(0, 1023);
      end
      sweep(4'($urandom_range(0, 15)), f, cd, 1'b0);
    end

    q_run.push_back(0);
    pulse_start(4'b0001);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk_i); #1;
      if (mes_run_o) begin ok = 1; break; end
    end
    chk("reach_run", int'(ok), 1);
    arstn_i = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_run", int'(mes_run_o), 0);
    chk("mid_rst_mes_arstn", int'(mes_arstn_o), 0);
    chk("mid_rst_ch_sel", int'(ch_sel_o), 0);
    chk("mid_rst_err", int'(err_o), 0);
    chk("mid_rst_vld", int'(res_vld_o), 0);
    chk("mid_rst_code", int'(res_code_o), 0);
    q_run.delete();
    q_sum.delete();
    for (int c = 0; c < CH_N; c++) out_q[c].delete();
    repeat (2) @(negedge clk_i);
    #2 arstn_i = 1'b1;
    saw = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (done_o) saw = 1;
    end
    chk("no_done_after_rst", int'(saw), 0);
    chk("post_rst_mes_arstn", int'(mes_arstn_o), 1);
    chk("runs_all_seen", q_run.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
